// File: rtl/up_pkg.sv
// Shared encodings for the microprocessor state controller.
// Top-level states, boot copier sub-states and image limits.
package up_pkg;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSING = 2'd2,
      ST_PAUSED  = 2'd3
   } state_e;

   typedef enum logic {
      SUB_REQ = 1'b0,
      SUB_WR  = 1'b1
   } boot_sub_e;

   localparam int IMG_MAX = 32768;
   localparam int IDX_W   = $clog2(IMG_MAX);

endpackage

// File: rtl/boot_copier.sv
// Copies IMG_WORDS words from storage into main memory, two cycles per word
// at best; pulses done during the write of the last word.
module boot_copier
   import up_pkg::*;
#(
   parameter int IMG_WORDS = 1024
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_en,
   input  logic [15:0]      i_stData,
   input  logic             i_stAck,
   output logic             o_stReq,
   output logic [IDX_W-1:0] o_stAddr,
   output logic [15:0]      o_memAddr,
   output logic [15:0]      o_memData,
   output logic             o_memWr,
   output logic             o_done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_WORDS - 1);

   boot_sub_e        sub_q, sub_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      data_q, data_d;
   logic             req_q, req_d;
   logic             wr_q, wr_d;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         sub_q  <= SUB_REQ;
         idx_q  <= '0;
         data_q <= '0;
         req_q  <= 1'b0;
         wr_q   <= 1'b0;
      end else begin
         sub_q  <= sub_d;
         idx_q  <= idx_d;
         data_q <= data_d;
         req_q  <= req_d;
         wr_q   <= wr_d;
      end
   end

   // An ack only counts while the request is actually on the wire.
   always_comb begin
      sub_d  = sub_q;
      idx_d  = idx_q;
      data_d = data_q;
      req_d  = req_q;
      wr_d   = wr_q;
      o_done = 1'b0;
      case (sub_q)
         SUB_REQ: begin
            if (!i_en) begin
               req_d = 1'b0;
            end else if (req_q && i_stAck) begin
               req_d  = 1'b0;
               wr_d   = 1'b1;
               data_d = i_stData;
               sub_d  = SUB_WR;
            end else begin
               req_d = 1'b1;
            end
         end
         SUB_WR: begin
            wr_d  = 1'b0;
            sub_d = SUB_REQ;
            if (idx_q == LAST_IDX) begin
               o_done = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
               req_d = i_en;
            end
         end
         default: ;
      endcase
   end

   assign o_stReq   = req_q;
   assign o_stAddr  = idx_q;
   assign o_memAddr = {idx_q, 1'b0};
   assign o_memData = data_q;
   assign o_memWr   = wr_q;

endmodule

// File: rtl/up_state_ctrl.sv
// Boots the core from storage, then sequences pause/resume and halt through
// the core's start-pause/now-paused handshake and muxes the memory port.
module up_state_ctrl
   import up_pkg::*;
#(
   parameter int IMG_WORDS = 1024
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   output logic        o_stReq,
   output logic [14:0] o_stAddr,
   input  logic [15:0] i_stData,
   input  logic        i_stAck,
   input  logic [15:0] i_coreMemAddr,
   input  logic [15:0] i_coreMemData,
   input  logic        i_coreMemWr,
   output logic [15:0] o_memAddr,
   output logic [15:0] o_memData,
   output logic        o_memWr,
   output logic        o_smIsBooted,
   output logic        o_smStartPause,
   input  logic        i_smNowPaused,
   input  logic        i_coreHLT,
   input  logic        i_pauseReq,
   input  logic        i_resumeReq,
   output logic [1:0]  o_state
);

   state_e      state_q, state_d;
   logic        booted_q, booted_d;
   logic        sp_q, sp_d;
   logic        cp_done;
   logic [15:0] cp_addr, cp_data;
   logic        cp_wr;

   boot_copier #(
      .IMG_WORDS(IMG_WORDS)
   ) u_copier (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_en     (state_q == ST_BOOT),
      .i_stData (i_stData),
      .i_stAck  (i_stAck),
      .o_stReq  (o_stReq),
      .o_stAddr (o_stAddr),
      .o_memAddr(cp_addr),
      .o_memData(cp_data),
      .o_memWr  (cp_wr),
      .o_done   (cp_done)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q  <= ST_BOOT;
         booted_q <= 1'b0;
         sp_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         booted_q <= booted_d;
         sp_q     <= sp_d;
      end
   end

   // Pause wins over a simultaneous resume while paused.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:    if (cp_done) state_d = ST_RUN;
         ST_RUN:     if (i_pauseReq || i_coreHLT) state_d = ST_PAUSING;
         ST_PAUSING: if (i_smNowPaused) state_d = ST_PAUSED;
         ST_PAUSED:  if (i_resumeReq && !i_pauseReq) state_d = ST_RUN;
         default:    state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      booted_d = (state_d != ST_BOOT);
      sp_d     = (state_d == ST_PAUSING) || (state_d == ST_PAUSED);
      if (state_q == ST_BOOT) begin
         o_memAddr = cp_addr;
         o_memData = cp_data;
         o_memWr   = cp_wr;
      end else begin
         o_memAddr = i_coreMemAddr;
         o_memData = i_coreMemData;
         o_memWr   = i_coreMemWr;
      end
   end

   assign o_state        = state_q;
   assign o_smIsBooted   = booted_q;
   assign o_smStartPause = sp_q;

endmodule

// File: tb/tb_up_state_ctrl.sv
// Bench for up_state_ctrl: boot copy, pause/resume table, random run-phase
// traffic against a small behavioural model, and reset in mid-boot.
module tb_up_state_ctrl;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        st_req;
   logic [14:0] st_addr;
   logic [15:0] st_data;
   logic        st_ack;
   logic [15:0] c_addr, c_data;
   logic        c_wr;
   logic [15:0] m_addr, m_data;
   logic        m_wr;
   logic        booted, spause, now_p, hlt, p_req, r_req;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   int  ack_delay = 0;
   bit  stray_en  = 0;
   int  wcnt      = 0;
   bit  prev_req  = 0;
   bit  prev_ack  = 0;
   logic [14:0] prev_addr = '0;
   logic [31:0] wq[$];

   always #5 clk = ~clk;

   up_state_ctrl #(.IMG_WORDS(N)) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .o_stReq       (st_req),
      .o_stAddr      (st_addr),
      .i_stData      (st_data),
      .i_stAck       (st_ack),
      .i_coreMemAddr (c_addr),
      .i_coreMemData (c_data),
      .i_coreMemWr   (c_wr),
      .o_memAddr     (m_addr),
      .o_memData     (m_data),
      .o_memWr       (m_wr),
      .o_smIsBooted  (booted),
      .o_smStartPause(spause),
      .i_smNowPaused (now_p),
      .i_coreHLT     (hlt),
      .i_pauseReq    (p_req),
      .i_resumeReq   (r_req),
      .o_state       (state)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Storage model plus boot-phase monitor.
   always @(negedge clk) begin
      if (rstn && state == 2'd0) begin
         if (m_wr) wq.push_back({m_addr, m_data});
         check("boot_not_booted", 32'(booted), 32'd0);
         if (prev_req && !prev_ack) begin
            check("req_hold", 32'(st_req), 32'd1);
            check("addr_hold", 32'(st_addr), 32'(prev_addr));
         end
      end
      prev_req  = rstn && st_req;
      prev_addr = st_addr;
      if (st_req) begin
         st_data = 16'hA000 + 16'(st_addr);
         if (wcnt == ack_delay) begin
            st_ack = 1'b1;
            wcnt   = 0;
         end else begin
            st_ack = 1'b0;
            wcnt++;
         end
      end else begin
         st_data = 16'hDEAD;
         st_ack  = stray_en && ($urandom_range(0, 1) == 1);
         wcnt    = 0;
      end
      prev_ack = st_ack && st_req;
   end

   task automatic clear_ctl();
      p_req = 0; r_req = 0; hlt = 0; now_p = 0;
   endtask

   task automatic rand_core();
      c_addr = 16'($urandom);
      c_data = 16'($urandom);
      c_wr   = 1'($urandom);
   endtask

   task automatic check_reset();
      check("rst_state", 32'(state), 32'd0);
      check("rst_stReq", 32'(st_req), 32'd0);
      check("rst_stAddr", 32'(st_addr), 32'd0);
      check("rst_memWr", 32'(m_wr), 32'd0);
      check("rst_memAddr", 32'(m_addr), 32'd0);
      check("rst_memData", 32'(m_data), 32'd0);
      check("rst_booted", 32'(booted), 32'd0);
      check("rst_spause", 32'(spause), 32'd0);
   endtask

   task automatic wait_booted(input bit noise, output int cyc);
      cyc = 0;
      while (!booted && cyc < 2000) begin
         if (noise) begin
            p_req = 1'($urandom); r_req = 1'($urandom);
            hlt = 1'($urandom); now_p = 1'($urandom);
            rand_core();
         end
         @(posedge clk); #1;
         cyc++;
      end
      clear_ctl();
      check("boot_timeout", 32'(booted), 32'd1);
      check("boot_state", 32'(state), 32'd1);
   endtask

   task automatic check_writes();
      check("wr_count", 32'(wq.size()), 32'(N));
      for (int i = 0; i < N && i < wq.size(); i++) begin
         check("wr_addr", 32'(wq[i][31:16]), 32'(2 * i));
         check("wr_data", 32'(wq[i][15:0]), 32'h0000A000 + 32'(i));
      end
   endtask

   typedef struct {
      logic       p, r, h, np;
      logic [1:0] st;
      logic       sp;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int  cyc;
      bit  found;
      bit  want, cpd;
      logic [1:0] exp_st;

      tbl[0]  = '{1, 0, 0, 0, 2'd2, 1};
      tbl[1]  = '{1, 0, 0, 0, 2'd2, 1};
      tbl[2]  = '{0, 1, 0, 0, 2'd2, 1};
      tbl[3]  = '{0, 0, 0, 1, 2'd3, 1};
      tbl[4]  = '{1, 1, 0, 1, 2'd3, 1};
      tbl[5]  = '{1, 0, 0, 0, 2'd3, 1};
      tbl[6]  = '{0, 1, 0, 0, 2'd1, 0};
      tbl[7]  = '{0, 1, 0, 0, 2'd1, 0};
      tbl[8]  = '{0, 0, 1, 0, 2'd2, 1};
      tbl[9]  = '{0, 0, 1, 1, 2'd3, 1};
      tbl[10] = '{0, 1, 0, 0, 2'd1, 0};
      tbl[11] = '{0, 0, 0, 0, 2'd1, 0};
      tbl[12] = '{0, 0, 0, 1, 2'd1, 0};

      rstn = 0;
      st_ack = 0;
      st_data = '0;
      clear_ctl();
      c_addr = 16'h1234; c_data = 16'h5678; c_wr = 1;
      repeat (3) @(posedge clk);
      #1;
      check_reset();

      // Zero-wait boot: booted rises 2*N+1 edges after release.
      wq.delete();
      c_wr = 0;
      rstn = 1;
      wait_booted(0, cyc);
      check("boot_cycles", 32'(cyc), 32'(2 * N + 1));
      check_writes();
      check("run_stReq", 32'(st_req), 32'd0);

      foreach (tbl[i]) begin
         p_req = tbl[i].p; r_req = tbl[i].r;
         hlt = tbl[i].h; now_p = tbl[i].np;
         @(posedge clk); #1;
         check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
         check($sformatf("tbl%0d_sp", i), 32'(spause), 32'(tbl[i].sp));
      end
      clear_ctl();

      // Random run-phase traffic; the core has asked to pause once want is
      // set and has confirmed once cpd is set.
      want = 0; cpd = 0;
      repeat (400) begin
         p_req = ($urandom_range(0, 7) == 0);
         r_req = ($urandom_range(0, 4) == 0);
         hlt   = ($urandom_range(0, 9) == 0);
         now_p = ($urandom_range(0, 3) == 0);
         rand_core();
         #1;
         check("pt_addr", 32'(m_addr), 32'(c_addr));
         check("pt_data", 32'(m_data), 32'(c_data));
         check("pt_wr", 32'(m_wr), 32'(c_wr));
         @(posedge clk);
         if (!want) begin
            if (p_req || hlt) begin want = 1; cpd = 0; end
         end else if (!cpd) begin
            if (now_p) cpd = 1;
         end else if (r_req && !p_req) begin
            want = 0;
         end
         exp_st = !want ? 2'd1 : (cpd ? 2'd3 : 2'd2);
         #1;
         check("rnd_state", 32'(state), 32'(exp_st));
         check("rnd_sp", 32'(spause), 32'(want));
         check("rnd_booted", 32'(booted), 32'd1);
      end
      clear_ctl();

      // Wait-state boot with stray acks and boot-phase noise.
      rstn = 0;
      @(posedge clk); #1;
      check_reset();
      wq.delete();
      ack_delay = 3;
      stray_en = 1;
      rstn = 1;
      wait_booted(1, cyc);
      check_writes();
      stray_en = 0;
      ack_delay = 0;

      // Reset during the write of word 2.
      rstn = 0;
      @(posedge clk); #1;
      rstn = 1;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk); #1;
         if (m_wr && m_addr == 16'd4 && state == 2'd0) found = 1;
      end
      check("midboot_found", 32'(found), 32'd1);
      p_req = 1; r_req = 1; hlt = 1;
      rstn = 0;
      @(posedge clk); #1;
      check_reset();
      clear_ctl();
      wq.delete();
      rstn = 1;
      @(posedge clk); #1;
      check("restart_req", 32'(st_req), 32'd1);
      check("restart_addr", 32'(st_addr), 32'd0);
      wait_booted(1, cyc);
      check_writes();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
